// File: rtl/bram_arb_pkg.sv
// Shared types for the two-port BRAM arbiter: requester id, read tag, latency bound.
package bram_arb_pkg;

  typedef enum logic {
    REQ_P0 = 1'b0,
    REQ_P1 = 1'b1
  } req_id_t;

  typedef struct packed {
    logic    valid;
    req_id_t id;
  } tag_t;

  localparam int MAX_RD_LATENCY = 2;

endpackage

// File: rtl/bram_arb_rr.sv
// Two-way round-robin grant; the pointer remembers the last requester that completed a handshake.
module bram_arb_rr
  import bram_arb_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [1:0] i_valid,
  input  logic       i_accept,
  output logic [1:0] o_grant
);

  req_id_t r_last;

  // Reset to "p1 last" so p0 wins the first contention.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_last <= REQ_P1;
    end else if (i_accept) begin
      r_last <= o_grant[1] ? REQ_P1 : REQ_P0;
    end
  end

  always_comb begin
    o_grant = i_valid;
    if (&i_valid) begin
      o_grant = (r_last == REQ_P0) ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/bram_arbiter.sv
// Shares one BRAM port between p0 and p1 with round-robin arbitration and tagged read returns.
// Optional macro BRAM_ARB_OUTREG_EN adds one response register stage (read latency +1).
module bram_arbiter
  import bram_arb_pkg::*;
#(
  parameter int  MEM_WIDTH  = 64,
  parameter int  MEM_SIZE   = 1024,
  parameter int  RD_LATENCY = 1,
  localparam int ADDR_W     = $clog2(MEM_SIZE),
  localparam int BE_W       = MEM_WIDTH / 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_p0_valid,
  output logic                 o_p0_ready,
  input  logic [BE_W-1:0]      i_p0_we,
  input  logic [ADDR_W-1:0]    i_p0_addr,
  input  logic [MEM_WIDTH-1:0] i_p0_wdata,
  output logic                 o_p0_rsp_valid,
  output logic [MEM_WIDTH-1:0] o_p0_rsp_data,
  input  logic                 i_p1_valid,
  output logic                 o_p1_ready,
  input  logic [BE_W-1:0]      i_p1_we,
  input  logic [ADDR_W-1:0]    i_p1_addr,
  input  logic [MEM_WIDTH-1:0] i_p1_wdata,
  output logic                 o_p1_rsp_valid,
  output logic [MEM_WIDTH-1:0] o_p1_rsp_data,
  output logic                 o_bram_clk,
  output logic                 o_bram_rst,
  output logic                 o_bram_en,
  output logic [BE_W-1:0]      o_bram_we,
  output logic [ADDR_W-1:0]    o_bram_addr,
  output logic [MEM_WIDTH-1:0] o_bram_din,
  input  logic [MEM_WIDTH-1:0] i_bram_dout
);

  localparam int LAT = (RD_LATENCY < 1) ? 1 :
                       (RD_LATENCY > MAX_RD_LATENCY) ? MAX_RD_LATENCY : RD_LATENCY;

  logic [1:0]           w_valid;
  logic [1:0]           w_grant;
  logic [1:0]           w_ready;
  logic                 w_accept;
  req_id_t              w_win;
  logic [BE_W-1:0]      w_we;
  logic [ADDR_W-1:0]    w_addr;
  logic [MEM_WIDTH-1:0] w_wdata;
  tag_t                 w_new_tag;
  tag_t                 w_out_tag;
  logic [1:0]           w_rsp_valid;

  logic                 r_en;
  logic [BE_W-1:0]      r_we;
  logic [ADDR_W-1:0]    r_addr;
  logic [MEM_WIDTH-1:0] r_din;
  tag_t [LAT:0]         r_tags;

  assign w_valid = {i_p1_valid, i_p0_valid};

  bram_arb_rr u_rr (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_valid  (w_valid),
    .i_accept (w_accept),
    .o_grant  (w_grant)
  );

  assign w_ready    = w_grant & {2{~i_rst}};
  assign w_accept   = |(w_ready & w_valid);
  assign w_win      = w_grant[1] ? REQ_P1 : REQ_P0;
  assign o_p0_ready = w_ready[0];
  assign o_p1_ready = w_ready[1];

  always_comb begin
    w_we    = i_p0_we;
    w_addr  = i_p0_addr;
    w_wdata = i_p0_wdata;
    if (w_win == REQ_P1) begin
      w_we    = i_p1_we;
      w_addr  = i_p1_addr;
      w_wdata = i_p1_wdata;
    end
  end

  // Address and write data hold between commands; only en/we drop when idle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_en   <= 1'b0;
      r_we   <= '0;
      r_addr <= '0;
      r_din  <= '0;
    end else begin
      r_en <= w_accept;
      r_we <= w_accept ? w_we : '0;
      if (w_accept) begin
        r_addr <= w_addr;
        r_din  <= w_wdata;
      end
    end
  end

  assign o_bram_clk  = i_clk;
  assign o_bram_rst  = i_rst;
  assign o_bram_en   = r_en;
  assign o_bram_we   = r_we;
  assign o_bram_addr = r_addr;
  assign o_bram_din  = r_din;

  always_comb begin
    w_new_tag       = '0;
    w_new_tag.valid = w_accept & ~(|w_we);
    w_new_tag.id    = w_win;
  end

  // Stage k is visible k+1 cycles after accept, so stage LAT lines up with bram_dout.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_tags <= '0;
    end else begin
      r_tags <= {r_tags[LAT-1:0], w_new_tag};
    end
  end

  assign w_out_tag      = r_tags[LAT];
  assign w_rsp_valid[0] = w_out_tag.valid & (w_out_tag.id == REQ_P0);
  assign w_rsp_valid[1] = w_out_tag.valid & (w_out_tag.id == REQ_P1);

`ifdef BRAM_ARB_OUTREG_EN
  logic [1:0]           r_rsp_valid;
  logic [MEM_WIDTH-1:0] r_rsp_data0;
  logic [MEM_WIDTH-1:0] r_rsp_data1;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rsp_valid <= '0;
      r_rsp_data0 <= '0;
      r_rsp_data1 <= '0;
    end else begin
      r_rsp_valid <= w_rsp_valid;
      if (w_rsp_valid[0]) r_rsp_data0 <= i_bram_dout;
      if (w_rsp_valid[1]) r_rsp_data1 <= i_bram_dout;
    end
  end

  assign o_p0_rsp_valid = r_rsp_valid[0];
  assign o_p1_rsp_valid = r_rsp_valid[1];
  assign o_p0_rsp_data  = r_rsp_data0;
  assign o_p1_rsp_data  = r_rsp_data1;
`else
  logic [MEM_WIDTH-1:0] r_hold0;
  logic [MEM_WIDTH-1:0] r_hold1;

  // Data passes straight through on the valid cycle and is captured so it holds afterwards.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_hold0 <= '0;
      r_hold1 <= '0;
    end else begin
      if (w_rsp_valid[0]) r_hold0 <= i_bram_dout;
      if (w_rsp_valid[1]) r_hold1 <= i_bram_dout;
    end
  end

  assign o_p0_rsp_valid = w_rsp_valid[0];
  assign o_p1_rsp_valid = w_rsp_valid[1];
  assign o_p0_rsp_data  = w_rsp_valid[0] ? i_bram_dout : r_hold0;
  assign o_p1_rsp_data  = w_rsp_valid[1] ? i_bram_dout : r_hold1;
`endif

endmodule

// File: tb/tb_bram_arbiter.sv
// Directed bench: two arbiters (RD_LATENCY 1 and 2) share stimulus, each with its own BRAM model.
`timescale 1ns/1ps
module tb_bram_arbiter;

  localparam int W    = 64;
  localparam int BE   = 8;
  localparam int AW   = 10;
  localparam int MEMD = 1024;
`ifdef BRAM_ARB_OUTREG_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  logic          p0_valid, p1_valid;
  logic [BE-1:0] p0_we, p1_we;
  logic [AW-1:0] p0_addr, p1_addr;
  logic [W-1:0]  p0_wdata, p1_wdata;

  logic          a_p0_ready, a_p1_ready, a_p0_rsp_valid, a_p1_rsp_valid;
  logic [W-1:0]  a_p0_rsp_data, a_p1_rsp_data;
  logic          a_bram_clk, a_bram_rst, a_bram_en;
  logic [BE-1:0] a_bram_we;
  logic [AW-1:0] a_bram_addr;
  logic [W-1:0]  a_bram_din, a_bram_dout;

  logic          b_p0_ready, b_p1_ready, b_p0_rsp_valid, b_p1_rsp_valid;
  logic [W-1:0]  b_p0_rsp_data, b_p1_rsp_data;
  logic          b_bram_clk, b_bram_rst, b_bram_en;
  logic [BE-1:0] b_bram_we;
  logic [AW-1:0] b_bram_addr;
  logic [W-1:0]  b_bram_din, b_bram_dout;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bram_arbiter #(.MEM_WIDTH(W), .MEM_SIZE(MEMD), .RD_LATENCY(1)) u_dut_a (
    .i_clk(clk), .i_rst(rst),
    .i_p0_valid(p0_valid), .o_p0_ready(a_p0_ready), .i_p0_we(p0_we), .i_p0_addr(p0_addr),
    .i_p0_wdata(p0_wdata), .o_p0_rsp_valid(a_p0_rsp_valid), .o_p0_rsp_data(a_p0_rsp_data),
    .i_p1_valid(p1_valid), .o_p1_ready(a_p1_ready), .i_p1_we(p1_we), .i_p1_addr(p1_addr),
    .i_p1_wdata(p1_wdata), .o_p1_rsp_valid(a_p1_rsp_valid), .o_p1_rsp_data(a_p1_rsp_data),
    .o_bram_clk(a_bram_clk), .o_bram_rst(a_bram_rst), .o_bram_en(a_bram_en),
    .o_bram_we(a_bram_we), .o_bram_addr(a_bram_addr), .o_bram_din(a_bram_din),
    .i_bram_dout(a_bram_dout)
  );

  bram_arbiter #(.MEM_WIDTH(W), .MEM_SIZE(MEMD), .RD_LATENCY(2)) u_dut_b (
    .i_clk(clk), .i_rst(rst),
    .i_p0_valid(p0_valid), .o_p0_ready(b_p0_ready), .i_p0_we(p0_we), .i_p0_addr(p0_addr),
    .i_p0_wdata(p0_wdata), .o_p0_rsp_valid(b_p0_rsp_valid), .o_p0_rsp_data(b_p0_rsp_data),
    .i_p1_valid(p1_valid), .o_p1_ready(b_p1_ready), .i_p1_we(p1_we), .i_p1_addr(p1_addr),
    .i_p1_wdata(p1_wdata), .o_p1_rsp_valid(b_p1_rsp_valid), .o_p1_rsp_data(b_p1_rsp_data),
    .o_bram_clk(b_bram_clk), .o_bram_rst(b_bram_rst), .o_bram_en(b_bram_en),
    .o_bram_we(b_bram_we), .o_bram_addr(b_bram_addr), .o_bram_din(b_bram_din),
    .i_bram_dout(b_bram_dout)
  );

  // BRAM models: read-first, dout one (a) or two (b) cycles after en.
  logic [W-1:0] mem_a [MEMD];
  logic [W-1:0] mem_b [MEMD];
  logic [W-1:0] a_rd0, b_rd0, b_rd1;

  always @(posedge clk) begin
    if (a_bram_en) begin
      a_rd0 <= mem_a[a_bram_addr];
      for (int i = 0; i < BE; i++)
        if (a_bram_we[i]) mem_a[a_bram_addr][i*8 +: 8] <= a_bram_din[i*8 +: 8];
    end
    if (b_bram_en) begin
      b_rd0 <= mem_b[b_bram_addr];
      for (int j = 0; j < BE; j++)
        if (b_bram_we[j]) mem_b[b_bram_addr][j*8 +: 8] <= b_bram_din[j*8 +: 8];
    end
    b_rd1 <= b_rd0;
  end
  assign a_bram_dout = a_rd0;
  assign b_bram_dout = b_rd1;

  typedef struct {
    int           cyc;
    int           port;
    logic [W-1:0] data;
  } rsp_t;
  rsp_t qa[$];
  rsp_t qb[$];

  always @(negedge clk) begin
    if (a_p0_rsp_valid !== 1'b0) qa.push_back('{cyc, 0, a_p0_rsp_data});
    if (a_p1_rsp_valid !== 1'b0) qa.push_back('{cyc, 1, a_p1_rsp_data});
    if (b_p0_rsp_valid !== 1'b0) qb.push_back('{cyc, 0, b_p0_rsp_data});
    if (b_p1_rsp_valid !== 1'b0) qb.push_back('{cyc, 1, b_p1_rsp_data});
  end

  // Called at a negedge; returns at the negedge after acceptance with valid dropped.
  task automatic do_req(input int port, input logic [BE-1:0] we, input logic [AW-1:0] addr,
                        input logic [W-1:0] data, output int acc);
    acc = -1;
    if (port == 0) begin
      p0_valid = 1'b1; p0_we = we; p0_addr = addr; p0_wdata = data;
    end else begin
      p1_valid = 1'b1; p1_we = we; p1_addr = addr; p1_wdata = data;
    end
    for (int n = 0; n < 10 && acc < 0; n++) begin
      #1;
      if (((port == 0) ? a_p0_ready : a_p1_ready) === 1'b1) acc = cyc;
      @(negedge clk);
    end
    if (acc < 0) begin
      checks++; errors++;
      $display("[TB] FAIL req_timeout port %0d got no ready required ready within 10 cycles", port);
    end
    if (port == 0) p0_valid = 1'b0;
    else           p1_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [9:0] flags;
    rst = 1'b1;
    p0_valid = 1'b1; p0_we = '0; p0_addr = '0; p0_wdata = '0;
    p1_valid = 1'b1; p1_we = '0; p1_addr = '0; p1_wdata = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      flags = {a_p0_ready, a_p1_ready, a_bram_en, a_p0_rsp_valid, a_p1_rsp_valid,
               b_p0_ready, b_p1_ready, b_bram_en, b_p0_rsp_valid, b_p1_rsp_valid};
      checks++;
      if (flags !== 10'b0) begin
        errors++;
        $display("[TB] FAIL reset_flags cycle %0d got %b required 0000000000", i, flags);
      end
    end
    checks++;
    if ({a_bram_we, a_bram_addr, a_bram_din, a_p0_rsp_data, a_p1_rsp_data,
         b_bram_we, b_bram_addr, b_bram_din} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_regs got nonzero we=%h addr=%h din=%h rsp0=%h required all 0",
               a_bram_we, a_bram_addr, a_bram_din, a_p0_rsp_data);
    end
    checks++;
    if ({a_bram_rst, b_bram_rst, a_bram_clk, b_bram_clk} !== {2'b11, clk, clk}) begin
      errors++;
      $display("[TB] FAIL bram_clk_rst got %b required %b",
               {a_bram_rst, b_bram_rst, a_bram_clk, b_bram_clk}, {2'b11, clk, clk});
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({a_p1_ready, a_p0_ready, b_p1_ready, b_p0_ready} !== 4'b0101) begin
      errors++;
      $display("[TB] FAIL first_grant got %b required 0101",
               {a_p1_ready, a_p0_ready, b_p1_ready, b_p0_ready});
    end
    @(negedge clk);
    p0_valid = 1'b0; p1_valid = 1'b0;
    checks++;
    if ({a_bram_en, b_bram_en} !== 2'b11) begin
      errors++;
      $display("[TB] FAIL first_cmd_en got %b required 11", {a_bram_en, b_bram_en});
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic test_write_read();
    int acc;
    qa.delete(); qb.delete();
    do_req(0, 8'hFF, 10'h010, 64'hA5A5, acc);
    checks++;
    if ({a_bram_en, a_bram_we, a_bram_addr, a_bram_din} !== {1'b1, 8'hFF, 10'h010, 64'hA5A5} ||
        {b_bram_en, b_bram_we, b_bram_addr, b_bram_din} !== {1'b1, 8'hFF, 10'h010, 64'hA5A5}) begin
      errors++;
      $display("[TB] FAIL write_cmd got en=%b we=%h addr=%h din=%h required en=1 we=ff addr=010 din=a5a5",
               a_bram_en, a_bram_we, a_bram_addr, a_bram_din);
    end
    do_req(0, 8'h00, 10'h010, 64'h0, acc);
    checks++;
    if ({a_bram_en, a_bram_we, b_bram_en, b_bram_we} !== {1'b1, 8'h00, 1'b1, 8'h00}) begin
      errors++;
      $display("[TB] FAIL read_cmd got en=%b we=%h required en=1 we=00", a_bram_en, a_bram_we);
    end
    repeat (6) @(negedge clk); #2;
    checks++;
    if (qa.size() != 1 || qb.size() != 1) begin
      errors++;
      $display("[TB] FAIL wr_rsp_count got a=%0d b=%0d required 1 and 1", qa.size(), qb.size());
    end else begin
      checks++;
      if (qa[0].port != 0 || qa[0].cyc != acc + 2 + EXTRA || qa[0].data !== 64'hA5A5) begin
        errors++;
        $display("[TB] FAIL wr_rsp_a got port=%0d cyc=%0d data=%h required port=0 cyc=%0d data=a5a5",
                 qa[0].port, qa[0].cyc, qa[0].data, acc + 2 + EXTRA);
      end
      checks++;
      if (qb[0].port != 0 || qb[0].cyc != acc + 3 + EXTRA || qb[0].data !== 64'hA5A5) begin
        errors++;
        $display("[TB] FAIL wr_rsp_b got port=%0d cyc=%0d data=%h required port=0 cyc=%0d data=a5a5",
                 qb[0].port, qb[0].cyc, qb[0].data, acc + 3 + EXTRA);
      end
    end
    checks++;
    if ({a_p0_rsp_valid, a_p0_rsp_data, b_p0_rsp_valid, b_p0_rsp_data} !==
        {1'b0, 64'hA5A5, 1'b0, 64'hA5A5}) begin
      errors++;
      $display("[TB] FAIL rsp_hold got a=%h b=%h required a5a5 with valid low",
               a_p0_rsp_data, b_p0_rsp_data);
    end
  endtask

  task automatic test_round_robin();
    int acc;
    int start;
    logic [1:0] expReady;
    do_req(0, 8'hFF, 10'h001, 64'h1111, acc);
    do_req(1, 8'hFF, 10'h002, 64'h2222, acc);
    repeat (4) @(negedge clk);
    qa.delete(); qb.delete();
    p0_valid = 1'b1; p0_we = '0; p0_addr = 10'h001;
    p1_valid = 1'b1; p1_we = '0; p1_addr = 10'h002;
    start = cyc;
    for (int i = 0; i < 8; i++) begin
      #1;
      expReady = (i % 2 == 0) ? 2'b01 : 2'b10;
      checks++;
      if ({a_p1_ready, a_p0_ready} !== expReady || {b_p1_ready, b_p0_ready} !== expReady) begin
        errors++;
        $display("[TB] FAIL rr_grant cycle %0d got a=%b b=%b required %b", i,
                 {a_p1_ready, a_p0_ready}, {b_p1_ready, b_p0_ready}, expReady);
      end
      if (i > 0) begin
        checks++;
        if ({a_bram_en, b_bram_en} !== 2'b11) begin
          errors++;
          $display("[TB] FAIL rr_en cycle %0d got %b required 11", i, {a_bram_en, b_bram_en});
        end
      end
      @(negedge clk);
    end
    p0_valid = 1'b0; p1_valid = 1'b0;
    checks++;
    if ({a_bram_en, b_bram_en} !== 2'b11) begin
      errors++;
      $display("[TB] FAIL rr_en_last got %b required 11", {a_bram_en, b_bram_en});
    end
    repeat (6) @(negedge clk); #2;
    checks++;
    if (qa.size() != 8 || qb.size() != 8) begin
      errors++;
      $display("[TB] FAIL rr_rsp_count got a=%0d b=%0d required 8 and 8", qa.size(), qb.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        checks++;
        if (qa[k].port != k % 2 || qa[k].cyc != start + k + 2 + EXTRA ||
            qa[k].data !== ((k % 2 == 0) ? 64'h1111 : 64'h2222) ||
            qb[k].port != k % 2 || qb[k].cyc != start + k + 3 + EXTRA ||
            qb[k].data !== ((k % 2 == 0) ? 64'h1111 : 64'h2222)) begin
          errors++;
          $display("[TB] FAIL rr_rsp %0d got a(port=%0d cyc=%0d data=%h) b(port=%0d cyc=%0d) required port=%0d cyc=%0d/%0d",
                   k, qa[k].port, qa[k].cyc, qa[k].data, qb[k].port, qb[k].cyc,
                   k % 2, start + k + 2 + EXTRA, start + k + 3 + EXTRA);
        end
      end
    end
  endtask

  task automatic test_byte_write();
    int acc;
    qa.delete(); qb.delete();
    do_req(0, 8'hFF, 10'h005, 64'h1122334455667788, acc);
    do_req(1, 8'h01, 10'h005, 64'h00000000000000FF, acc);
    checks++;
    if ({a_bram_we, a_bram_din, b_bram_we} !== {8'h01, 64'hFF, 8'h01}) begin
      errors++;
      $display("[TB] FAIL byte_we got we=%h din=%h required we=01 din=ff", a_bram_we, a_bram_din);
    end
    do_req(0, 8'h00, 10'h005, 64'h0, acc);
    repeat (6) @(negedge clk); #2;
    checks++;
    if (qa.size() != 1 || qb.size() != 1) begin
      errors++;
      $display("[TB] FAIL byte_rsp_count got a=%0d b=%0d required 1 and 1", qa.size(), qb.size());
    end else begin
      checks++;
      if (qa[0].data !== 64'h11223344556677FF || qa[0].cyc != acc + 2 + EXTRA ||
          qb[0].data !== 64'h11223344556677FF || qb[0].cyc != acc + 3 + EXTRA) begin
        errors++;
        $display("[TB] FAIL byte_rsp got a=%h@%0d b=%h@%0d required 11223344556677ff@%0d/%0d",
                 qa[0].data, qa[0].cyc, qb[0].data, qb[0].cyc, acc + 2 + EXTRA, acc + 3 + EXTRA);
      end
    end
  endtask

  task automatic test_reset_midflight();
    int acc;
    qa.delete(); qb.delete();
    do_req(0, 8'h00, 10'h001, 64'h0, acc);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk); #2;
    checks++;
    if (qa.size() != 0 || qb.size() != 0) begin
      errors++;
      $display("[TB] FAIL flush_rsp got a=%0d b=%0d responses required 0 and 0", qa.size(), qb.size());
    end
    checks++;
    if ({a_p0_rsp_data, b_p0_rsp_data} !== '0) begin
      errors++;
      $display("[TB] FAIL flush_data got a=%h b=%h required 0", a_p0_rsp_data, b_p0_rsp_data);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got no finish required finish before 200000ns");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1;
    p0_valid = 1'b0; p0_we = '0; p0_addr = '0; p0_wdata = '0;
    p1_valid = 1'b0; p1_we = '0; p1_addr = '0; p1_wdata = '0;
    test_reset();
    test_write_read();
    test_round_robin();
    test_byte_write();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
